// File: rtl/adc_sample_averager_if.sv
// ----------------------------------------------------------------------------
// adc_sample_averager_if
//   Output port bundle of the sample averager. The averager drives it through
//   the master modport; the register/readout logic attaches as the slave.
//
//   avg_value_o  master->slave  NBITS  window mean
//   avg_valid_o  master->slave  1      mean available, held until accepted
//   avg_ready_i  slave->master  1      consumer accepts on valid && ready
//   min_o/max_o  master->slave  NBITS  window min/max (ADC_AVG_MINMAX_EN only)
// ----------------------------------------------------------------------------
interface adc_sample_averager_if #(
  parameter int NBITS = 6
);
  logic [NBITS-1:0] avg_value_o;
  logic             avg_valid_o;
  logic             avg_ready_i;
`ifdef ADC_AVG_MINMAX_EN
  logic [NBITS-1:0] min_o;
  logic [NBITS-1:0] max_o;

  modport master (output avg_value_o, avg_valid_o, min_o, max_o, input avg_ready_i);
  modport slave  (input avg_value_o, avg_valid_o, min_o, max_o, output avg_ready_i);
`else
  modport master (output avg_value_o, avg_valid_o, input avg_ready_i);
  modport slave  (input avg_value_o, avg_valid_o, output avg_ready_i);
`endif
endinterface

// File: rtl/adc_sample_averager.sv
// ----------------------------------------------------------------------------
// adc_sample_averager
//   Boxcar averager behind the ramp/PWM ADC stage. Each non-overlapping window
//   of 2**LOG2_AVG samples is reduced to one rounded mean, presented on a
//   valid/ready port. Means that complete while the output is still full are
//   discarded and counted in a saturating drop counter.
//
//   Optional feature macro: ADC_AVG_MINMAX_EN adds per-window min/max outputs
//   (min_o/max_o on the output interface), loaded together with the mean.
//
//   clk_i        in   1       system clock, rising edge
//   rst_i        in   1       synchronous reset, active high
//   enable_i     in   1       averaging enable; low discards a partial window
//   adc_value_i  in   NBITS   ADC sample
//   adc_valid_i  in   1       one-cycle strobe per conversion (cannot stall)
//   avg_if       master       avg_value_o / avg_valid_o / avg_ready_i (+min/max)
//   drop_cnt_o   out  DROP_W  means discarded while output full, saturating
//   busy_o       out  1       partial window held
//
// FSM states
//   state    | meaning
//   ST_IDLE  | averaging disabled, window held empty, samples ignored
//   ST_ACCUM | averaging enabled, qualified samples accumulate
// ----------------------------------------------------------------------------
module adc_sample_averager #(
  parameter int NBITS    = 6,
  parameter int LOG2_AVG = 2,
  parameter int DROP_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [NBITS-1:0]      adc_value_i,
  input  logic                  adc_valid_i,
  adc_sample_averager_if.master avg_if,
  output logic [DROP_W-1:0]     drop_cnt_o,
  output logic                  busy_o
);

  localparam int AW = NBITS + LOG2_AVG;
  localparam int SW = AW + 1;
  localparam int CW = (LOG2_AVG == 0) ? 1 : LOG2_AVG;

  localparam logic [CW-1:0]     CNT_LAST = CW'((2 ** LOG2_AVG) - 1);
  // Half an LSB of the shifted result; integer division makes it 0 for LOG2_AVG=0.
  localparam logic [SW-1:0]     RND      = SW'((2 ** LOG2_AVG) / 2);
  localparam logic [SW-1:0]     MEAN_MAX = SW'((2 ** NBITS) - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             take_sample;
  logic             clear_win;

  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] avg_value_q, avg_value_d;
  logic             avg_valid_q, avg_valid_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             busy_q, busy_d;

  logic [SW-1:0]    sum;
  logic [SW-1:0]    mean_full;
  logic [NBITS-1:0] mean_sat;
  logic             win_done;
  logic             out_accept;
  logic             load_out;
  logic             drop_out;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable_i)  state_d = ST_ACCUM;
      ST_ACCUM: if (!enable_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. A sample in the cycle enable falls is dropped because
  // enable_i itself gates take_sample, not only the registered state.
  always_comb begin
    take_sample = 1'b0;
    clear_win   = 1'b1;
    if (state_q == ST_ACCUM && enable_i) begin
      take_sample = adc_valid_i;
      clear_win   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Window arithmetic
  // --------------------------------------------------------------------------
  always_comb begin
    sum       = {1'b0, acc_q} + SW'(adc_value_i) + RND;
    mean_full = sum >> LOG2_AVG;
    mean_sat  = (mean_full > MEAN_MAX) ? MEAN_MAX[NBITS-1:0] : mean_full[NBITS-1:0];
    win_done  = take_sample && (cnt_q == CNT_LAST);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_win || win_done) begin
      // Completion restarts the window in the same cycle, so no sample is lost.
      acc_d = '0;
      cnt_d = '0;
    end else if (take_sample) begin
      acc_d = acc_q + AW'(adc_value_i);
      cnt_d = cnt_q + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output register and drop counter
  // --------------------------------------------------------------------------
  always_comb begin
    out_accept = avg_valid_q && avg_if.avg_ready_i;
    // Loading is allowed when empty, or when the held mean leaves this cycle.
    load_out   = win_done && (!avg_valid_q || avg_if.avg_ready_i);
    drop_out   = win_done && !load_out;

    avg_valid_d = avg_valid_q;
    if (load_out) begin
      avg_valid_d = 1'b1;
    end else if (out_accept) begin
      avg_valid_d = 1'b0;
    end

    avg_value_d = load_out ? mean_sat : avg_value_q;

    drop_cnt_d = drop_cnt_q;
    if (drop_out && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_value_q <= '0;
      avg_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_value_q <= avg_value_d;
      avg_valid_q <= avg_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign avg_if.avg_value_o = avg_value_q;
  assign avg_if.avg_valid_o = avg_valid_q;
  assign drop_cnt_o         = drop_cnt_q;
  assign busy_o             = busy_q;

`ifdef ADC_AVG_MINMAX_EN
  // --------------------------------------------------------------------------
  // Per-window min/max. The running values are only meaningful once the window
  // holds a sample, so the first sample (cnt_q == 0) overwrites them.
  // --------------------------------------------------------------------------
  logic [NBITS-1:0] min_run_q, min_run_d;
  logic [NBITS-1:0] max_run_q, max_run_d;
  logic [NBITS-1:0] min_q, min_d;
  logic [NBITS-1:0] max_q, max_d;
  logic [NBITS-1:0] win_min;
  logic [NBITS-1:0] win_max;

  always_comb begin
    if (cnt_q == '0) begin
      win_min = adc_value_i;
      win_max = adc_value_i;
    end else begin
      win_min = (adc_value_i < min_run_q) ? adc_value_i : min_run_q;
      win_max = (adc_value_i > max_run_q) ? adc_value_i : max_run_q;
    end

    min_run_d = take_sample ? win_min : min_run_q;
    max_run_d = take_sample ? win_max : max_run_q;
    min_d     = load_out ? win_min : min_q;
    max_d     = load_out ? win_max : max_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_run_q <= '0;
      max_run_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      min_run_q <= min_run_d;
      max_run_q <= max_run_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign avg_if.min_o = min_q;
  assign avg_if.max_o = max_q;
`endif

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Sits directly downstream of the ramp/PWM ADC stage. It consumes that stage's adc_value/adc_valid sample stream.
- Boxcar-averages each non-overlapping window of 2**LOG2_AVG samples into one rounded mean.
- Presents each mean on a valid/ready output port for the register/readout logic.
- Counts averages lost to backpressure in a saturating drop counter.

Parameters:
- NBITS, 6, ADC sample width; must match the ADC stage.
- LOG2_AVG, 2, log2 of window length (0..8); 0 means registered pass-through.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  system clock, all logic rising-edge.
- rst_i  input  1  synchronous reset, active-high.
- enable_i  input  1  averaging enable; low discards any partial window.
- adc_value_i  input  NBITS  ADC sample, qualified by adc_valid_i.
- adc_valid_i  input  1  one-cycle strobe per conversion; no ready, cannot be stalled.
- avg_value_o  output  NBITS  window mean.
- avg_valid_o  output  1  mean available; held until accepted.
- avg_ready_i  input  1  consumer accepts when avg_valid_o && avg_ready_i.
- drop_cnt_o  output  DROP_W  number of means discarded while output full; saturates.
- busy_o  output  1  high while a partial window is held (sample count != 0).

Behaviour:
- Reset (rst_i high at clock edge): accumulator=0, sample count=0, avg_value_o=0, avg_valid_o=0, drop_cnt_o=0, busy_o=0. Reset wins over every other event in the same cycle, including a mid-window reset.
- States:
  - IDLE (enable_i low): samples are ignored; accumulator and count are held at 0.
  - ACCUM (enable_i high): each sample with adc_valid_i high adds to the accumulator and increments the count.
  - IDLE->ACCUM on enable_i rising. ACCUM->IDLE on enable_i falling, clearing the accumulator and count in that same cycle.
- Output register independence:
  - It is not cleared by enable_i; a pending mean stays valid until accepted.
  - A sample arriving in the same cycle enable_i falls is discarded.
- Accumulator: NBITS+LOG2_AVG bits, cannot overflow.
- Window completion: a sample arrives while count == 2**LOG2_AVG-1.
  - sum = acc + adc_value_i + 2**(LOG2_AVG-1), computed on NBITS+LOG2_AVG+1 bits; the rounding term is 0 when LOG2_AVG=0.
  - mean = sum >> LOG2_AVG, saturated to 2**NBITS-1.
  - The accumulator and count restart at 0 in the same cycle, so the next sample starts a new window with no gap.
- Latency: avg_valid_o rises on the clock edge after the completing sample's cycle (1 cycle).
- Output load rule on completion:
  - Load if avg_valid_o==0, or if avg_valid_o && avg_ready_i in that cycle (simultaneous accept + load keeps avg_valid_o high with the new value).
  - Otherwise discard the new mean, keep the old one, and increment drop_cnt_o; it saturates at 2**DROP_W-1 with no wrap.
- Accept without a new mean: avg_valid_o falls on the next edge; avg_value_o holds its last value.
- avg_value_o must not change while avg_valid_o && !avg_ready_i.
- busy_o = (count != 0), registered.

Optional Feature:
- Macro ADC_AVG_MINMAX_EN; the feature adds ports min_o and max_o (NBITS each).
- With the macro defined:
  - Per-window running min and max are tracked, restarted with the window.
  - They are loaded into min_o/max_o at the same time and under the same load/drop rules as avg_value_o.
  - Reset value is 0.
- Without the macro: the ports and logic are absent. The rest of the block behaves identically.

Test Plan:
- NBITS=6, LOG2_AVG=2, ready=1, samples 10,11,12,13 -> one cycle after 4th strobe avg_valid_o=1, avg_value_o=12 ((46+2)>>2); drop_cnt_o=0.
- Samples 63,63,63,63 -> avg_value_o=63 (254>>2, no saturation wrap); then 0,0,0,1 -> avg_value_o=0; then 0,0,1,1 -> 1.
- ready=0, two full windows (10x4, 20x4) -> avg_value_o stays 10, drop_cnt_o=1. Raise ready while a third window (30x4) completes in the same cycle -> avg_valid_o stays 1, value 30, drop_cnt_o=1.
- Two samples of 40, enable_i low 3 cycles (busy_o goes 0), enable high, samples 8,8,8,8 -> avg_value_o=8. rst_i pulsed after 2 samples of a window gives the same result on a fresh window.
- Force 300 drops with DROP_W=8 -> drop_cnt_o=255, no wrap. LOG2_AVG=0: each sample appears on avg_value_o one cycle later, unchanged.
- ADC_AVG_MINMAX_EN defined, samples 5,60,20,1 -> avg_value_o=22, min_o=1, max_o=60; next window 30x4 -> min_o=max_o=30.
